// File: rtl/rtc_status_pkg.sv
// Shared definitions for the RTC status-write sequencer: FSM encoding,
// requester identifiers, default addresses and the round-robin pick.
package rtc_status_pkg;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] CARGA      = 3'd1;
    localparam logic [2:0] CAPTURA    = 3'd2;
    localparam logic [2:0] ESPERA_BUS = 3'd3;
    localparam logic [2:0] ESCRIBE    = 3'd4;
    localparam logic [2:0] ESPERA_FIN = 3'd5;

    typedef enum logic {
        REQ_FH    = 1'b0,
        REQ_CRONO = 1'b1
    } req_id_t;

    localparam logic [1:0] MODO_CFG_DEF  = 2'd3;
    localparam logic [7:0] DIR_FH_DEF    = 8'h00;
    localparam logic [7:0] DIR_CRONO_DEF = 8'h00;
    localparam int         TIMEOUT_DEF   = 255;

    // On a tie the requester that was not served last wins.
    function automatic req_id_t arbitrar(input logic    pend_fh,
                                         input logic    pend_cr,
                                         input req_id_t ultimo);
        req_id_t ganador;
        if (pend_fh && pend_cr) begin
            if (ultimo == REQ_FH) begin
                ganador = REQ_CRONO;
            end else begin
                ganador = REQ_FH;
            end
        end else if (pend_fh) begin
            ganador = REQ_FH;
        end else begin
            ganador = REQ_CRONO;
        end
        return ganador;
    endfunction

endpackage

// File: rtl/detector_cambio.sv
// Level-change detector with a sticky pending flag. A change seen on the
// same edge as a clear wins, so no toggle is ever lost.
module detector_cambio (
    input  logic clk,
    input  logic srst,
    input  logic nivel_i,
    input  logic clr_i,
    output logic pend_o
);

    logic nivel_q;
    logic pend_q;
    logic pend_d;

    assign pend_d = (pend_q & ~clr_i) | (nivel_i ^ nivel_q);
    assign pend_o = pend_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            nivel_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            nivel_q <= nivel_i;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: rtl/control_escritura_status.sv
// Arbitrates hour-format and chrono status-write requests, pulses the
// modificar_status enable, captures its byte and drives the RTC bus write.
module control_escritura_status
    import rtc_status_pkg::*;
#(
    parameter logic [7:0] DIR_FH    = DIR_FH_DEF,
    parameter logic [7:0] DIR_CRONO = DIR_CRONO_DEF,
    parameter logic [1:0] MODO_CFG  = MODO_CFG_DEF,
    parameter int         TIMEOUT   = TIMEOUT_DEF
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic [1:0] Control,
    input  logic       F_H,
    input  logic       act_crono,
    input  logic [7:0] Mod_s,
    input  logic       bus_listo,
    input  logic       bus_fin,
    output logic       enable_status_fh,
    output logic       enable_status_crono,
    output logic [7:0] dir_out,
    output logic [7:0] dato_out,
    output logic       inicio_esc,
    output logic       ocupado,
    output logic       error_to
);

    localparam int              CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CUENTA_MAX = CW'(TIMEOUT);

    logic [2:0]    estado_q, estado_d;
    req_id_t       sel_q, sel_d;
    req_id_t       ultimo_q, ultimo_d;
    logic [CW-1:0] cuenta_q, cuenta_d;
    logic [7:0]    dir_q, dir_d;
    logic [7:0]    dato_q, dato_d;
    logic          error_q, error_d;

    // Index 0 is the hour-format requester, index 1 the chrono requester.
    logic [1:0] nivel;
    logic [1:0] pend;
    logic [1:0] clr;

    assign nivel = {act_crono, F_H};
    assign clr   = {enable_status_crono, enable_status_fh};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_detector
            detector_cambio u_detector (
                .clk     (reloj),
                .srst    (resetM),
                .nivel_i (nivel[gi]),
                .clr_i   (clr[gi]),
                .pend_o  (pend[gi])
            );
        end
    endgenerate

    always_comb begin
        estado_d = estado_q;
        sel_d    = sel_q;
        ultimo_d = ultimo_q;
        cuenta_d = cuenta_q;
        dir_d    = dir_q;
        dato_d   = dato_q;
        error_d  = error_q;
        case (estado_q)
            IDLE: begin
                if ((Control == MODO_CFG) && (pend != 2'b00)) begin
                    sel_d    = arbitrar(pend[0], pend[1], ultimo_q);
                    estado_d = CARGA;
                end
            end
            CARGA: begin
                ultimo_d = sel_q;
                estado_d = CAPTURA;
            end
            CAPTURA: begin
                dato_d   = Mod_s;
                dir_d    = (sel_q == REQ_FH) ? DIR_FH : DIR_CRONO;
                estado_d = ESPERA_BUS;
            end
            ESPERA_BUS: begin
                if (bus_listo) begin
                    estado_d = ESCRIBE;
                end
            end
            ESCRIBE: begin
                cuenta_d = '0;
                estado_d = ESPERA_FIN;
            end
            ESPERA_FIN: begin
                // A timed-out request is dropped; its pending flag was already cleared.
                if (bus_fin) begin
                    estado_d = IDLE;
                end else if (cuenta_q == CUENTA_MAX) begin
                    error_d  = 1'b1;
                    estado_d = IDLE;
                end else begin
                    cuenta_d = cuenta_q + CW'(1);
                end
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            estado_q <= IDLE;
            sel_q    <= REQ_FH;
            ultimo_q <= REQ_CRONO;
            cuenta_q <= '0;
            dir_q    <= 8'h00;
            dato_q   <= 8'h00;
            error_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            sel_q    <= sel_d;
            ultimo_q <= ultimo_d;
            cuenta_q <= cuenta_d;
            dir_q    <= dir_d;
            dato_q   <= dato_d;
            error_q  <= error_d;
        end
    end

    assign enable_status_fh    = (estado_q == CARGA) && (sel_q == REQ_FH);
    assign enable_status_crono = (estado_q == CARGA) && (sel_q == REQ_CRONO);
    assign inicio_esc          = (estado_q == ESCRIBE);
    assign ocupado             = (estado_q != IDLE);
    assign dir_out             = dir_q;
    assign dato_out            = dato_q;
    assign error_to            = error_q;

endmodule

// File: tb/tb_control_escritura_status.sv
// Scoreboard bench: stimulus pushes expected enables and bus writes; a
// monitor pops them as the DUT presents enable/inicio_esc pulses.
module tb_control_escritura_status;

    localparam logic [7:0] DIR_FH_TB = 8'h21;
    localparam logic [7:0] DIR_CR_TB = 8'h22;
    localparam logic [1:0] EN_FH     = 2'b10;
    localparam logic [1:0] EN_CR     = 2'b01;

    logic       reloj = 1'b0;
    logic       resetM;
    logic [1:0] Control;
    logic       F_H;
    logic       act_crono;
    logic [7:0] Mod_s;
    logic       bus_listo;
    logic       bus_fin;
    logic       enable_status_fh;
    logic       enable_status_crono;
    logic [7:0] dir_out;
    logic [7:0] dato_out;
    logic       inicio_esc;
    logic       ocupado;
    logic       error_to;

    control_escritura_status #(
        .DIR_FH    (DIR_FH_TB),
        .DIR_CRONO (DIR_CR_TB),
        .MODO_CFG  (2'd3),
        .TIMEOUT   (255)
    ) dut (
        .reloj               (reloj),
        .resetM              (resetM),
        .Control             (Control),
        .F_H                 (F_H),
        .act_crono           (act_crono),
        .Mod_s               (Mod_s),
        .bus_listo           (bus_listo),
        .bus_fin             (bus_fin),
        .enable_status_fh    (enable_status_fh),
        .enable_status_crono (enable_status_crono),
        .dir_out             (dir_out),
        .dato_out            (dato_out),
        .inicio_esc          (inicio_esc),
        .ocupado             (ocupado),
        .error_to            (error_to)
    );

    always #5 reloj = ~reloj;

    logic [15:0] exp_txn[$];
    logic [1:0]  exp_en[$];
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          en_cyc    = -100;
    int          fin_delay = 5;
    logic [7:0]  mod_fh    = 8'h00;
    logic [7:0]  mod_cr    = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired, got no event expected one (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({enable_status_fh, enable_status_crono, inicio_esc, ocupado,
                    error_to, dir_out, dato_out});
    endfunction

    // Monitor: enables and write starts are matched against the scoreboard.
    initial begin
        forever begin
            @(negedge reloj);
            cyc++;
            if (enable_status_fh || enable_status_crono) begin
                en_cyc = cyc;
                if (exp_en.size() == 0) begin
                    chk("enable_unexpected", 32'({enable_status_fh, enable_status_crono}), 32'd0);
                end else begin
                    chk("enable_id", 32'({enable_status_fh, enable_status_crono}),
                        32'(exp_en.pop_front()));
                end
            end
            if (inicio_esc) begin
                $display("txn: cycle=%0d dir_out=%02h dato_out=%02h", cyc, dir_out, dato_out);
                chk("enable_to_inicio", 32'(cyc - en_cyc), 32'd3);
                if (exp_txn.size() == 0) begin
                    chk("inicio_unexpected", 32'(inicio_esc), 32'd0);
                end else begin
                    chk("txn_dir_dato", 32'({dir_out, dato_out}), 32'(exp_txn.pop_front()));
                end
            end
        end
    end

    // Model of modificar_status: byte becomes valid the cycle after its enable.
    initial begin
        Mod_s = 8'h00;
        forever begin
            @(negedge reloj);
            if (enable_status_fh) begin
                Mod_s = mod_fh;
            end else if (enable_status_crono) begin
                Mod_s = mod_cr;
            end
        end
    end

    // Bus controller model: completes fin_delay cycles after the write start.
    initial begin
        bus_fin = 1'b0;
        forever begin
            @(negedge reloj);
            if (inicio_esc && (fin_delay > 0)) begin
                repeat (fin_delay) @(negedge reloj);
                bus_fin = 1'b1;
                @(negedge reloj);
                bus_fin = 1'b0;
                chk("ocupado_after_fin", 32'(ocupado), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge reloj);
            if (exp_txn.size() == 0 && exp_en.size() == 0 && !ocupado) begin
                done = 1'b1;
            end
        end
        if (!done) bound_fail("drain");
    endtask

    task automatic wait_en(input logic [1:0] which);
        bit done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge reloj);
            if ({enable_status_fh, enable_status_crono} == which) done = 1'b1;
        end
        if (!done) bound_fail("wait_enable");
    endtask

    task automatic wait_inicio();
        bit done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge reloj);
            if (inicio_esc) done = 1'b1;
        end
        if (!done) bound_fail("wait_inicio");
    endtask

    initial begin
        resetM    = 1'b1;
        Control   = 2'd3;
        F_H       = 1'b0;
        act_crono = 1'b0;
        bus_listo = 1'b1;
        repeat (3) @(negedge reloj);
        resetM = 1'b0;

        // Quiet after reset with both levels low.
        for (int i = 0; i < 20; i++) begin
            @(negedge reloj);
            chk("reset_quiet", all_outs(), 32'd0);
        end

        // Single hour-format request.
        mod_fh = 8'hA5;
        exp_en.push_back(EN_FH);
        exp_txn.push_back({DIR_FH_TB, 8'hA5});
        F_H = 1'b1;
        drain();

        // Chrono toggle held off by Control, released by Control=3.
        Control   = 2'd0;
        act_crono = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge reloj);
            chk("ctrl0_idle", 32'({ocupado, enable_status_crono}), 32'd0);
        end
        mod_cr = 8'h3C;
        exp_en.push_back(EN_CR);
        exp_txn.push_back({DIR_CR_TB, 8'h3C});
        Control = 2'd3;
        @(negedge reloj);
        chk("ctrl3_start", 32'(enable_status_crono), 32'd1);
        drain();

        // Tie after a chrono service: FH first.
        mod_fh = 8'h11;
        mod_cr = 8'h22;
        exp_en.push_back(EN_FH);
        exp_txn.push_back({DIR_FH_TB, 8'h11});
        exp_en.push_back(EN_CR);
        exp_txn.push_back({DIR_CR_TB, 8'h22});
        F_H       = 1'b0;
        act_crono = 1'b0;
        drain();

        // FH alone, so the next tie goes to CRONO.
        mod_fh = 8'h33;
        exp_en.push_back(EN_FH);
        exp_txn.push_back({DIR_FH_TB, 8'h33});
        F_H = 1'b1;
        drain();

        mod_fh = 8'h44;
        mod_cr = 8'h55;
        exp_en.push_back(EN_CR);
        exp_txn.push_back({DIR_CR_TB, 8'h55});
        exp_en.push_back(EN_FH);
        exp_txn.push_back({DIR_FH_TB, 8'h44});
        F_H       = 1'b0;
        act_crono = 1'b1;
        drain();

        // Toggle during its own transaction is served again.
        mod_fh = 8'h66;
        exp_en.push_back(EN_FH);
        exp_txn.push_back({DIR_FH_TB, 8'h66});
        exp_en.push_back(EN_FH);
        exp_txn.push_back({DIR_FH_TB, 8'h77});
        F_H = 1'b1;
        wait_en(EN_FH);
        repeat (2) @(negedge reloj);
        mod_fh = 8'h77;
        F_H    = 1'b0;
        drain();

        // Timeout: no bus_fin ever.
        fin_delay = -1;
        mod_cr    = 8'h88;
        exp_en.push_back(EN_CR);
        exp_txn.push_back({DIR_CR_TB, 8'h88});
        act_crono = 1'b0;
        wait_inicio();
        repeat (256) @(negedge reloj);
        chk("timeout_before", 32'({error_to, ocupado}), 32'b01);
        @(negedge reloj);
        chk("timeout_at", 32'({error_to, ocupado}), 32'b10);
        fin_delay = 5;

        mod_fh = 8'h99;
        exp_en.push_back(EN_FH);
        exp_txn.push_back({DIR_FH_TB, 8'h99});
        F_H = 1'b1;
        drain();
        chk("error_sticky", 32'(error_to), 32'd1);

        // Reset while waiting for the bus.
        bus_listo = 1'b0;
        exp_en.push_back(EN_FH);
        F_H = 1'b0;
        wait_en(EN_FH);
        repeat (2) @(negedge reloj);
        chk("in_espera_bus", 32'({ocupado, inicio_esc}), 32'b10);
        resetM = 1'b1;
        @(negedge reloj);
        chk("reset_mid", all_outs(), 32'd0);
        resetM    = 1'b0;
        bus_listo = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge reloj);
            chk("post_reset_quiet",
                32'({ocupado, inicio_esc, enable_status_fh, enable_status_crono}), 32'd0);
        end

        chk("exp_en_empty", 32'(exp_en.size()), 32'd0);
        chk("exp_txn_empty", 32'(exp_txn.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
